// File: rtl/maxnet_loader_if.sv
// Upstream word stream into the MaxNet loader: a valid/ready handshake carrying one WIDTH-bit word.
interface maxnet_loader_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/maxnet_loader.sv
// MaxNet write-side front end: collects N activations plus an N*N weight matrix from a word stream,
// presents them on flat X/W buses and hands the frame to the controller with a one-cycle start pulse.
module maxnet_loader #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    maxnet_loader_if.slave                   s_in,
    input  logic                             net_busy,
    input  logic                             net_done,
    output logic [N*WIDTH-1:0]               x_flat,
    output logic [N*N*WIDTH-1:0]             w_flat,
    output logic                             loaded,
    output logic                             start,
    output logic [$clog2(N+N*N+1)-1:0]       word_cnt
);
    localparam int FRAME = N + N*N;
    localparam int CW    = $clog2(FRAME + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_ARM,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [FRAME];
    logic             w_fill;
    logic             w_ready;
    logic             w_accept;
    logic             w_last;

    // in_ready is held low for the whole reset cycle, whatever state the register holds.
    assign w_ready        = w_fill && !rst;
    assign s_in.in_ready  = w_ready;
    assign w_accept       = s_in.in_valid && w_ready;
    assign w_last         = (r_cnt == CW'(FRAME - 1));
    assign word_cnt       = r_cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next = r_state;
        w_fill = 1'b0;
        loaded = 1'b0;
        start  = 1'b0;
        case (r_state)
            S_FILL: begin
                w_fill = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                loaded = 1'b1;
                start  = !net_busy;
                if (!net_busy) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                loaded = 1'b1;
                if (net_done) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            // NOTE: the frame storage is cleared on reset because the datapath reads it directly as X/W.
            for (int k = 0; k < FRAME; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_cnt] <= s_in.in_data;
            r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Words 0..N-1 are activations, the remaining N*N are the row-major weights.
    for (genvar gi = 0; gi < N; gi++) begin : g_x
        assign x_flat[gi*WIDTH +: WIDTH] = r_mem[gi];
    end

    for (genvar gj = 0; gj < N*N; gj++) begin : g_w
        assign w_flat[gj*WIDTH +: WIDTH] = r_mem[N + gj];
    end
endmodule

// File: tb/tb_maxnet_loader.sv
// Randomised scoreboard bench for maxnet_loader: a frame-level reference model predicts every start
// pulse and the frame it must carry; directed phases cover reset, gaps, busy hold-off and lockout.
module tb_maxnet_loader;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int FRAME = N + N*N;
    localparam int CW    = $clog2(FRAME + 1);

    typedef struct {
        logic [WIDTH-1:0] w [FRAME];
        int               e;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 net_busy = 1'b0;
    logic                 net_done = 1'b0;
    logic [N*WIDTH-1:0]   x_flat;
    logic [N*N*WIDTH-1:0] w_flat;
    logic                 loaded;
    logic                 start;
    logic [CW-1:0]        word_cnt;

    maxnet_loader_if #(.WIDTH(WIDTH)) bus ();

    maxnet_loader #(.WIDTH(WIDTH), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_in     (bus),
        .net_busy (net_busy),
        .net_done (net_done),
        .x_flat   (x_flat),
        .w_flat   (w_flat),
        .loaded   (loaded),
        .start    (start),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_count = 0;

    // Reference model: the frame as the spec defines it, plus the queue of frames awaiting start.
    logic [WIDTH-1:0] model_mem [FRAME];
    int               model_cnt = 0;
    int               last_acc_cyc = 0;
    exp_t             sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] dut_word(input int k);
        if (k < N) return x_flat[k*WIDTH +: WIDTH];
        return w_flat[(k-N)*WIDTH +: WIDTH];
    endfunction

    task automatic check_storage(input string name);
        for (int k = 0; k < FRAME; k++) check($sformatf("%s[%0d]", name, k), dut_word(k), model_mem[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < FRAME; k++) model_mem[k] = '0;
        model_cnt = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d);
        exp_t ex;
        model_mem[model_cnt] = d;
        model_cnt++;
        last_acc_cyc = cyc;
        if (model_cnt == FRAME) begin
            model_cnt = 0;
            for (int k = 0; k < FRAME; k++) ex.w[k] = model_mem[k];
            ex.e = cyc;
            sb.push_back(ex);
        end
    endtask

    // Offers one word (optionally after an idle cycle) and waits, bounded, for the handshake.
    task automatic send_word(input logic [WIDTH-1:0] d, input bit gap);
        bit ok = 1'b0;
        int waited = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (ok) model_accept(d);
        else check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_done();
        net_done = 1'b1;
        @(posedge clk); #1;
        net_done = 1'b0;
    endtask

    // Monitor: once a frame is due, start must stay low while busy and pulse on the first idle cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && cyc >= sb[0].e) begin
                if (net_busy) begin
                    check("start_held_busy", {31'd0, start}, 32'd0);
                end else begin
                    check("start_pulse", {31'd0, start}, 32'd1);
                    check("loaded_at_start", {31'd0, loaded}, 32'd1);
                    for (int k = 0; k < FRAME; k++)
                        check($sformatf("frame_word[%0d]", k), dut_word(k), sb[0].w[k]);
                    void'(sb.pop_front());
                end
            end else if (start === 1'b1) begin
                check("spurious_start", {31'd0, start}, 32'd0);
            end
            if (start === 1'b1) start_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int starts_before;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();

        // Reset: in_ready forced low during rst, then the reset state.
        @(negedge clk);
        check("ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_loaded", {31'd0, loaded}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check_storage("rst_storage");
        @(posedge clk); #1;

        // Reset then fill with 1..20, back to back.
        send_word(32'd1, 1'b0);
        first_acc = last_acc_cyc;
        for (int v = 2; v <= FRAME; v++) send_word(32'(v), 1'b0);
        check("fill_contiguous", 32'(last_acc_cyc - first_acc), 32'(FRAME - 1));
        @(negedge clk);
        check("fill_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check("fill_x0", dut_word(0), 32'd1);
        check("fill_x3", dut_word(3), 32'd4);
        check("fill_w0", dut_word(N), 32'd5);
        check("fill_w15", dut_word(FRAME - 1), 32'd20);
        @(posedge clk); #1;

        // Lockout in RUN, then net_done releases the loader.
        bus.in_data = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("run_ready_low", {31'd0, bus.in_ready}, 32'd0);
            check("run_loaded", {31'd0, loaded}, 32'd1);
            check("run_word_cnt", 32'(word_cnt), 32'd0);
            check_storage("run_storage");
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        pulse_done();
        @(negedge clk);
        check("done_ready_high", {31'd0, bus.in_ready}, 32'd1);
        check("done_loaded_low", {31'd0, loaded}, 32'd0);
        @(posedge clk); #1;
        send_word(32'h55, 1'b0);
        @(negedge clk);
        check("next_x0", dut_word(0), 32'h55);
        check("next_word_cnt", 32'(word_cnt), 32'd1);
        check_storage("next_storage");
        @(posedge clk); #1;
        for (int i = 1; i < FRAME; i++) send_word($urandom, 1'b0);
        @(posedge clk); #1;
        pulse_done();

        // Gapped valid: same words 1..20, idle cycle before each.
        for (int v = 1; v <= FRAME; v++) begin
            send_word(32'(v), 1'b1);
            if (v < FRAME) begin
                @(negedge clk);
                check("gap_word_cnt", 32'(word_cnt), 32'(model_cnt));
                @(posedge clk); #1;
                @(negedge clk);
                check("gap_word_cnt_idle", 32'(word_cnt), 32'(model_cnt));
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        pulse_done();

        // Busy hold-off: net_busy high at frame completion, released 5 cycles later.
        net_busy = 1'b1;
        for (int i = 0; i < FRAME; i++) send_word($urandom, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arm_loaded", {31'd0, loaded}, 32'd1);
            check("arm_ready_low", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        net_busy = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_run_start_low", {31'd0, start}, 32'd0);
        check("busy_run_loaded", {31'd0, loaded}, 32'd1);
        @(posedge clk); #1;
        pulse_done();

        // Spurious net_done in FILL and in ARM.
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
        pulse_done();
        @(negedge clk);
        check("spur_fill_cnt", 32'(word_cnt), 32'd7);
        check("spur_fill_ready", {31'd0, bus.in_ready}, 32'd1);
        check("spur_fill_loaded", {31'd0, loaded}, 32'd0);
        @(posedge clk); #1;
        net_busy = 1'b1;
        for (int i = 7; i < FRAME; i++) send_word($urandom, 1'b0);
        pulse_done();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("spur_arm_loaded", {31'd0, loaded}, 32'd1);
            check("spur_arm_ready", {31'd0, bus.in_ready}, 32'd0);
            check("spur_arm_cnt", 32'(word_cnt), 32'd0);
            @(posedge clk); #1;
        end
        net_busy = 1'b0;
        @(posedge clk); #1;
        pulse_done();

        // Reset mid-frame discards the partial frame and clears storage.
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_cnt", 32'(word_cnt), 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check_storage("mid_rst_storage");
        @(posedge clk); #1;
        starts_before = start_count;
        for (int v = 100; v < 100 + FRAME; v++) send_word(32'(v), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_x0", dut_word(0), 32'd100);
        check("mid_rst_w15", dut_word(FRAME - 1), 32'd119);
        check("mid_rst_one_start", 32'(start_count - starts_before), 32'd1);
        pulse_done();

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
